// File: rtl/bn_scheduler.sv
// Shares one combinational batch-norm datapath across n_neurons membranes.
// Per-neuron parameters sit in a small register file written through the config port.
module bn_scheduler #(
  parameter int n_stage   = 6,
  parameter int n_neurons = 4,
  parameter int aw        = 2,
  localparam int W        = n_stage + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [n_neurons*W-1:0] in_u,
  input  logic                   cfg_we,
  output logic                   cfg_ready,
  input  logic [aw-1:0]          cfg_addr,
  input  logic [3:0]             cfg_factor,
  input  logic [W-1:0]           cfg_addend,
  output logic [W-1:0]           bn_u,
  output logic [3:0]             bn_factor,
  output logic [W-1:0]           bn_addend,
  input  logic [W-1:0]           bn_u_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [n_neurons*W-1:0] out_u,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]    FAC_IDENTITY = 4'b0100;
  localparam logic [aw-1:0] IDX_LAST     = aw'(n_neurons - 1);

  state_t        state_q, state_d;
  logic [aw-1:0] idx_q, idx_d;

  logic [W-1:0] in_buf_q  [n_neurons];
  logic [W-1:0] out_buf_q [n_neurons];
  logic [3:0]   fac_q     [n_neurons];
  logic [W-1:0] add_q     [n_neurons];

  logic accept;
  logic cfg_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        // idx parks on the last neuron through DONE; only the accept path rewinds it.
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign cfg_ready  = (state_q != RUN);
  assign cfg_commit = cfg_we && cfg_ready && (int'(cfg_addr) < n_neurons);
  assign busy       = (state_q == RUN) || (state_q == DONE);

  // A config write landing on the accept edge is visible to the first RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < n_neurons; i++) begin
        in_buf_q[i]  <= '0;
        out_buf_q[i] <= '0;
        fac_q[i]     <= FAC_IDENTITY;
        add_q[i]     <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < n_neurons; i++) begin
          in_buf_q[i] <= in_u[i*W +: W];
        end
      end
      if (state_q == RUN) begin
        out_buf_q[idx_q] <= bn_u_out;
      end
      if (cfg_commit) begin
        fac_q[cfg_addr] <= cfg_factor;
        add_q[cfg_addr] <= cfg_addend;
      end
    end
  end

  always_comb begin
    bn_u      = '0;
    bn_factor = '0;
    bn_addend = '0;
    if (state_q == RUN) begin
      bn_u      = in_buf_q[idx_q];
      bn_factor = fac_q[idx_q];
      bn_addend = add_q[idx_q];
    end
  end

  always_comb begin
    out_u = '0;
    for (int i = 0; i < n_neurons; i++) begin
      out_u[i*W +: W] = out_buf_q[i];
    end
  end

endmodule

// File: doc/bn_scheduler.md
Name: bn_scheduler

Overview:
- Time-multiplexes one shared batch-normalization datapath across `n_neurons` membrane values.
- Holds the per-neuron BN parameters (factor, addend) in a small register file, loaded through a config port.
- Accepts a packed membrane vector through a valid/ready handshake and feeds the shared datapath one neuron per cycle.
- Collects the normalized results and presents them as a packed vector through a second valid/ready handshake.
- Sits between the neuron-layer membrane update and the spike/threshold stage.

Parameters:
- n_stage, 6, membrane width W = n_stage+2 bits.
- n_neurons, 4, number of neurons sharing the datapath (>=2).
- aw, 2, config address width, $clog2(n_neurons).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  membrane vector valid.
- in_ready  output  1  block can accept a vector.
- in_u  input  n_neurons*W  packed membranes, neuron i at bits [i*W +: W].
- cfg_we  input  1  parameter write strobe.
- cfg_ready  output  1  parameter writes accepted.
- cfg_addr  input  aw  neuron index.
- cfg_factor  input  4  BN factor code.
- cfg_addend  input  W  BN addend.
- bn_u  output  W  operand to shared datapath.
- bn_factor  output  4  factor to shared datapath.
- bn_addend  output  W  addend to shared datapath.
- bn_u_out  input  W  combinational result from shared datapath.
- out_valid  output  1  result vector valid.
- out_ready  input  1  consumer accepts result.
- out_u  output  n_neurons*W  packed normalized membranes.
- busy  output  1  high in RUN or DONE.

Behaviour:
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_u into in_buf, set idx=0, go to RUN.
  - RUN: drive bn_u=in_buf[idx], bn_factor=fac[idx], bn_addend=add[idx]. Capture bn_u_out into out_buf[idx] at the clock edge. idx++. When idx==n_neurons-1, go to DONE after that capture.
  - DONE: out_valid=1, out_u=out_buf. On out_ready, go to IDLE.
- in_ready=0 outside IDLE. out_valid=0 outside DONE.
- Latency: handshake accepted at edge T. RUN occupies cycles T..T+n_neurons-1. out_valid rises after edge T+n_neurons. Throughput is one vector per n_neurons+2 cycles minimum.
- DONE→IDLE and a new input accept happen on separate cycles; no overlap.
- bn_u, bn_factor and bn_addend are 0 outside RUN.
- out_u and out_buf hold their value until the next RUN overwrites each slot.
- The datapath is combinational, and the block adds no arithmetic. Results are taken as W bits exactly as returned; wrap-around is the datapath's.
- Config port:
  - cfg_ready = (state != RUN).
  - A write commits when cfg_we & cfg_ready & cfg_addr < n_neurons. Otherwise it is dropped silently.
  - A write in IDLE on the same edge as an input accept is committed before the first RUN cycle reads the parameters, so the new value is used.
  - Writes in DONE affect only the next vector.
- Reset values:
  - state=IDLE, idx=0, in_buf=0, out_buf=0.
  - fac[i]=4'b0100, the identity code: datapath output = u + addend.
  - add[i]=0.
  - Outputs: in_ready=1, cfg_ready=1, out_valid=0, busy=0, bn_*=0, out_u=0.
- Reset asserted mid-RUN or mid-DONE aborts the vector immediately and asynchronously restores all reset values, including the parameter file. No partial result is ever presented.
- idx never exceeds n_neurons-1, and wraps to 0 only through the IDLE accept path.

Test Plan:
(Bench instantiates the shared datapath on the bn_* ports; n_stage=6, W=8, n_neurons=4.)
- After reset, send in_u lanes {10,20,30,40} → out_valid exactly 4 cycles after the accept edge; out_u={10,20,30,40}; bn_factor=4'b0100 observed in all 4 RUN cycles.
- Write neuron1 factor=4'b0110, addend=5, and neuron3 factor=4'b1011, addend=200; then send {10,20,30,40} → out_u={10,65,30,18}, the last lane wrapping mod 256.
- Hold out_ready=0 for 3 cycles in DONE → out_valid and out_u stable; in_ready=0; a second in_valid is not accepted until 1 cycle after the out_ready handshake.
- cfg_we pulses during RUN (addr 0, factor 4'b0111) and cfg_addr out of range (n_neurons=3 build, addr 3) → cfg_ready=0 in RUN; the result and parameter file are unchanged; the dropped writes leave no effect.
- Drop rst_n during the second RUN cycle → in_ready=1, out_valid=0, bn_*=0 immediately. The next vector {1,2,3,4} returns {1,2,3,4}, showing the parameters were reset to identity.
- Config write to neuron0 (addend=7) on the same edge as an input accept of {9,0,0,0} → out_u lane0=16.
